// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO fed by committed stores, 8N1 serialiser.
// Define MMIO_UART_PARITY_EN for 8E1 framing with an even-parity bit.
module mmio_uart_tx #(
   parameter int unsigned CLK_HZ    = 50000000,
   parameter int unsigned BAUD      = 9600,
   parameter logic [7:0]  BASE_ADDR = 8'hF0,
   parameter int unsigned DEPTH     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] address,
   input  logic [7:0] wdata,
   input  logic       wren,
   input  logic       commit,
   output logic [7:0] rdata,
   output logic       rd_hit,
   output logic       tx,
   output logic       busy
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned AW           = $clog2(DEPTH);
   localparam int unsigned PW           = AW + 1;
   localparam logic [7:0]       STAT_ADDR = 8'(BASE_ADDR + 8'd1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef MMIO_UART_PARITY_EN
      PARITY,
`endif
      STOP
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       data_q, data_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             ovf_q, ovf_d;
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [7:0]       mem_q [DEPTH];

   logic [PW-1:0] count;
   logic          full;
   logic          empty;
   logic          push_req;
   logic          clr_req;
   logic          push;
   logic          pop;
   logic          cnt_end;
   logic [7:0]    head;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count    = wptr_q - rptr_q;
   assign full     = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
   assign empty    = (wptr_q == rptr_q);
   assign push_req = commit & wren & (address == BASE_ADDR);
   assign clr_req  = commit & wren & (address == STAT_ADDR);
   assign push     = push_req & ~full;
   assign cnt_end  = (cnt_q == CNT_LAST);
   assign head     = mem_q[rptr_q[AW-1:0]];

   // Frame sequencer; tx is computed for the next state so the line is a clean flop output.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      data_d  = data_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            tx_d  = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               data_d  = head;
               bit_d   = 3'd0;
               state_d = START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_end) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = DATA;
               tx_d    = data_q[0];
            end
         end
         DATA: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_end) begin
               cnt_d = '0;
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                  state_d = PARITY;
                  tx_d    = ^data_q;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  tx_d = data_q[bit_d];
               end
            end
         end
`ifdef MMIO_UART_PARITY_EN
         PARITY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_end) begin
               cnt_d   = '0;
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_end) begin
               cnt_d = '0;
               // Chain straight into the next start bit when data is waiting.
               if (!empty) begin
                  pop     = 1'b1;
                  data_d  = head;
                  bit_d   = 3'd0;
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // FIFO pointers and sticky overflow; a dropped push outranks a clear.
   always_comb begin
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(pop);
      ovf_d  = ovf_q;
      if (clr_req) ovf_d = 1'b0;
      if (push_req && full) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         data_q  <= 8'h00;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
      end
   end

   // Storage needs no reset; reset empties the FIFO through the pointers.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

   always_comb begin
      rdata = 8'h00;
      if (address == STAT_ADDR) rdata = {4'(count), 1'b0, ovf_q, busy_q, full};
   end

   assign rd_hit = (address == BASE_ADDR) || (address == STAT_ADDR);
   assign tx     = tx_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: queue-based reference model and expected line waveform.
module tb_mmio_uart_tx;

   localparam int unsigned CPB   = 16;
   localparam int unsigned DEPTH = 4;
   localparam logic [7:0]  BASE  = 8'hF0;
   localparam logic [7:0]  STAT  = 8'hF1;
`ifdef MMIO_UART_PARITY_EN
   localparam int unsigned FRAME = 11 * CPB;
`else
   localparam int unsigned FRAME = 10 * CPB;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] address;
   logic [7:0] wdata;
   logic       wren;
   logic       commit;
   logic [7:0] rdata;
   logic       rd_hit;
   logic       tx;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mq [$];
   logic       ovf_m;
   logic [7:0] vals [8];
   logic [7:0] cur;

   mmio_uart_tx #(.CLK_HZ(16), .BAUD(1), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .address(address),
      .wdata  (wdata),
      .wren   (wren),
      .commit (commit),
      .rdata  (rdata),
      .rd_hit (rd_hit),
      .tx     (tx),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected line level at cycle idx of a frame carrying byte b.
   function automatic logic exp_tx(input logic [7:0] b, input int idx);
      int slot;
      slot = idx / CPB;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
`ifdef MMIO_UART_PARITY_EN
      if (slot == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic cyc(input logic [7:0] b, input int idx);
      chk("tx_bit", 32'(tx), 32'(exp_tx(b, idx)));
      chk("busy_frame", 32'(busy), 32'd1);
   endtask

   task automatic run_frame(input logic [7:0] b, input int from);
      for (int k = from; k < int'(FRAME); k++) begin
         cyc(b, k);
         step();
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      address = a;
      wdata   = d;
      wren    = 1'b1;
      commit  = 1'b1;
      if (a == BASE) begin
         if (mq.size() == int'(DEPTH)) ovf_m = 1'b1;
         else mq.push_back(d);
      end else if (a == STAT) begin
         ovf_m = 1'b0;
      end
      step();
      commit = 1'b0;
      wren   = 1'b0;
   endtask

   task automatic rd_status(input logic busy_e);
      logic [7:0] e;
      e = {4'(mq.size()), 1'b0, ovf_m, busy_e, (mq.size() == int'(DEPTH))};
      address = STAT;
      #1;
      chk("status", 32'(rdata), 32'(e));
      chk("rd_hit_stat", 32'(rd_hit), 32'd1);
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         chk("tx_idle", 32'(tx), 32'd1);
         chk("busy_idle", 32'(busy), 32'd0);
         step();
      end
   endtask

   // First byte starts a frame, the rest are written during its first cycles.
   task automatic burst(input int n, input logic [7:0] v [8]);
      logic [7:0] c;
      wr(BASE, v[0]);
      chk("tx_pre_start", 32'(tx), 32'd1);
      chk("busy_pre_start", 32'(busy), 32'd0);
      step();
      c = mq.pop_front();
      for (int k = 0; k < n - 1; k++) begin
         cyc(c, k);
         wr(BASE, v[k+1]);
      end
      rd_status(1'b1);
      run_frame(c, n - 1);
      while (mq.size() > 0) begin
         c = mq.pop_front();
         run_frame(c, 0);
      end
      chk("tx_after", 32'(tx), 32'd1);
      chk("busy_after", 32'(busy), 32'd0);
      rd_status(1'b0);
   endtask

   initial begin
      rst     = 1'b0;
      address = 8'h00;
      wdata   = 8'h00;
      wren    = 1'b0;
      commit  = 1'b0;
      ovf_m   = 1'b0;
      repeat (3) step();
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      rd_status(1'b0);
      rst = 1'b1;

      address = BASE;
      #1;
      chk("data_addr_rdata", 32'(rdata), 32'd0);
      chk("data_addr_hit", 32'(rd_hit), 32'd1);
      address = 8'h37;
      #1;
      chk("miss_rdata", 32'(rdata), 32'd0);
      chk("miss_hit", 32'(rd_hit), 32'd0);
      address = 8'hF2;
      #1;
      chk("miss2_hit", 32'(rd_hit), 32'd0);
      idle_check(5);

      // Single 8'hA5 frame; busy window checked by run_frame plus busy_after.
      vals[0] = 8'hA5;
      burst(1, vals);
      idle_check(20);

      // Store level held with no commit is ignored; one commit gives one frame.
      address = BASE;
      wdata   = 8'($urandom);
      wren    = 1'b1;
      idle_check(60);
      wr(BASE, 8'($urandom));
      wren = 1'b1;
      step();
      cur = mq.pop_front();
      run_frame(cur, 0);
      wren = 1'b0;
      idle_check(100);
      rd_status(1'b0);

      // Overflow: head byte in flight, then 01..06 with 05 and 06 dropped.
      vals[0] = 8'($urandom);
      for (int i = 1; i <= 6; i++) vals[i] = 8'(i);
      burst(7, vals);
      wr(STAT, 8'($urandom));
      rd_status(1'b0);
      idle_check(5);

      // Randomized bursts, including back-to-back frames.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++) vals[i] = 8'($urandom);
         burst(int'($urandom_range(2, 6)), vals);
         if (ovf_m) wr(STAT, 8'($urandom));
         idle_check(3);
      end

      vals[0] = 8'h07;
      burst(1, vals);
      idle_check(5);

      // Reset mid-frame at cycle 40 while the line is low.
      wr(BASE, 8'($urandom) & 8'hFD);
      step();
      cur = mq.pop_front();
      cyc(cur, 0);
      wr(BASE, 8'($urandom));
      for (int k = 1; k < 40; k++) begin
         cyc(cur, k);
         step();
      end
      cyc(cur, 40);
      rst = 1'b0;
      #1;
      chk("rst_mid_tx", 32'(tx), 32'd1);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      mq.delete();
      ovf_m = 1'b0;
      rd_status(1'b0);
      step();
      rst = 1'b1;
      idle_check(300);
      rd_status(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
